// File: rtl/cf_fft_pkg.sv
// Shared constants for the cf_fft serial-to-parallel lane demux blocks.
//   DATA_W : default width of one sample lane
//   LANES  : number of output lanes per group (fixed)
//   S0..S3 : fill-counter encodings; the value is the lane the next sample lands in
package cf_fft_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned CNT_W  = 2;

  localparam logic [CNT_W-1:0] S0 = 2'd0;
  localparam logic [CNT_W-1:0] S1 = 2'd1;
  localparam logic [CNT_W-1:0] S2 = 2'd2;
  localparam logic [CNT_W-1:0] S3 = 2'd3;

  // Next fill position; wraps S3 -> S0 naturally in two bits.
  function automatic logic [CNT_W-1:0] cnt_advance(logic [CNT_W-1:0] cnt);
    return cnt + 2'd1;
  endfunction

endpackage

// File: rtl/cf_fft_1024_8_32_dmx4.sv
// Serial-to-4-lane demultiplexer with sync-based group alignment.
// Collects four consecutive accepted samples into one output word
// {lane3, lane2, lane1, lane0} and presents it with a valid/ready handshake.
//
// Ports:
//   clock_c   : clock, rising edge
//   reset_n_i : asynchronous active-low reset
//   enable_i  : gates acceptance of new samples (output drain is not gated)
//   valid_i   : upstream sample valid
//   sync_i    : current sample is lane 0 of a new group
//   data_i    : serial sample
//   ready_o   : a sample can be accepted this cycle
//   valid_o   : data_o holds a complete group
//   ready_i   : downstream consumes data_o this cycle
//   data_o    : registered group, lane0 in the LSBs
//   err_o     : one-cycle pulse when a partial group is dropped by a resync
module cf_fft_1024_8_32_dmx4 #(
  parameter int unsigned DATA_W = cf_fft_pkg::DATA_W,
  parameter int unsigned LANES  = cf_fft_pkg::LANES
) (
  input  logic                    clock_c,
  input  logic                    reset_n_i,
  input  logic                    enable_i,
  input  logic                    valid_i,
  input  logic                    sync_i,
  input  logic [DATA_W-1:0]       data_i,
  output logic                    ready_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [LANES*DATA_W-1:0] data_o,
  output logic                    err_o
);

  import cf_fft_pkg::*;

  localparam int unsigned FillW = (LANES - 1) * DATA_W;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FillW-1:0]        fill_q, fill_d;
  logic [LANES*DATA_W-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  logic accept;
  logic complete;

  // Lanes 0..2 sit in the fill buffer; the last lane is taken straight from
  // data_i on completion, so the fill buffer can keep collecting while the
  // output register waits for the downstream stage.
  assign ready_o  = enable_i && ((cnt_q != S3) || !valid_q || ready_i);
  assign accept   = enable_i && valid_i && ready_o;
  assign complete = accept && !sync_i && (cnt_q == S3);

  always_comb begin
    cnt_d  = cnt_q;
    fill_d = fill_q;
    err_d  = 1'b0;
    if (accept) begin
      if (sync_i) begin
        fill_d[DATA_W-1:0] = data_i;
        cnt_d              = S1;
        err_d              = (cnt_q != S0);
      end else begin
        for (int unsigned i = 0; i < LANES - 1; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            fill_d[i*DATA_W +: DATA_W] = data_i;
          end
        end
        cnt_d = cnt_advance(cnt_q);
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (complete) begin
      // A completing group overrides the drain so there is no bubble.
      data_d  = {data_i, fill_q};
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock_c or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q   <= S0;
      fill_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_cf_fft_1024_8_32_dmx4.sv
module tb_cf_fft_1024_8_32_dmx4;

  logic        clock_c = 1'b0;
  logic        reset_n_i;
  logic        enable_i, valid_i, sync_i, ready_i;
  logic [7:0]  data_i;
  logic        ready_o, valid_o, err_o;
  logic [31:0] data_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock_c = ~clock_c;

  cf_fft_1024_8_32_dmx4 #(.DATA_W(8), .LANES(4)) dut (
    .clock_c   (clock_c),
    .reset_n_i (reset_n_i),
    .enable_i  (enable_i),
    .valid_i   (valid_i),
    .sync_i    (sync_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .err_o     (err_o)
  );

  // Reference model: a queue of collected samples and one output slot.
  logic [7:0]  part[$];
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic m_ready(input logic en, input logic rdy);
    return en && (part.size() != 3 || !m_valid || rdy);
  endfunction

  task automatic model_reset();
    part.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_err   = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic v, input logic s,
                            input logic [7:0] d, input logic rdy);
    logic acc, newgrp;
    acc    = v && m_ready(en, rdy);
    newgrp = 1'b0;
    m_err  = 1'b0;
    if (acc) begin
      if (s) begin
        m_err = (part.size() != 0);
        part.delete();
        part.push_back(d);
      end else begin
        part.push_back(d);
        if (part.size() == 4) begin
          m_data = {part[3], part[2], part[1], part[0]};
          newgrp = 1'b1;
          part.delete();
        end
      end
    end
    if (newgrp) m_valid = 1'b1;
    else if (m_valid && rdy) m_valid = 1'b0;
  endtask

  // One clock: starts and ends at a falling edge.
  task automatic cyc(input logic en, input logic v, input logic s,
                     input logic [7:0] d, input logic rdy);
    enable_i = en;
    valid_i  = v;
    sync_i   = s;
    data_i   = d;
    ready_i  = rdy;
    #1;
    chk("ready_o", {31'd0, ready_o}, {31'd0, m_ready(en, rdy)});
    @(posedge clock_c);
    model_edge(en, v, s, d, rdy);
    @(negedge clock_c);
    chk("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
    chk("data_o", data_o, m_data);
    chk("err_o", {31'd0, err_o}, {31'd0, m_err});
  endtask

  // Reset asserted at a falling edge, outputs checked right away, released
  // at the next falling edge.
  task automatic do_reset();
    reset_n_i = 1'b0;
    enable_i  = 1'b0;
    valid_i   = 1'b0;
    sync_i    = 1'b0;
    data_i    = '0;
    ready_i   = 1'b0;
    #1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    model_reset();
    @(negedge clock_c);
    reset_n_i = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic        s;
    logic [7:0]  d;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Basic group, then a resync that must drop the A* partial group.
    tbl[0]  = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h44, 1'b1, 1'b1, 32'h4433_2211, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 32'h4433_2211, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 32'h4433_2211, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'hA2, 1'b1, 1'b0, 32'h4433_2211, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'hB1, 1'b1, 1'b0, 32'h4433_2211, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 8'hB2, 1'b1, 1'b0, 32'h4433_2211, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'hB3, 1'b1, 1'b0, 32'h4433_2211, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'hB4, 1'b1, 1'b1, 32'hB4B3_B2B1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'hB4B3_B2B1, 1'b0};

    model_reset();
    @(negedge clock_c);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].rdy);
      chk($sformatf("vec%0d_valid", i), {31'd0, valid_o}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d_data", i), data_o, tbl[i].ed);
      chk($sformatf("vec%0d_err", i), {31'd0, err_o}, {31'd0, tbl[i].ee});
    end

    // Backpressure: first group held, next three buffered, then one ready
    // cycle both drains and completes the second group.
    do_reset();
    for (int i = 1; i <= 7; i++) cyc(1'b1, 1'b1, i == 1, 8'(i), 1'b0);
    chk("bp_held_valid", {31'd0, valid_o}, 32'd1);
    chk("bp_held_data", data_o, 32'h0403_0201);
    enable_i = 1'b1; valid_i = 1'b1; sync_i = 1'b0; data_i = 8'h08; ready_i = 1'b0;
    #1;
    chk("bp_ready_low", {31'd0, ready_o}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 8'h08, 1'b0);
    chk("bp_still_held", data_o, 32'h0403_0201);
    cyc(1'b1, 1'b1, 1'b0, 8'h08, 1'b1);
    chk("bp_next_valid", {31'd0, valid_o}, 32'd1);
    chk("bp_next_data", data_o, 32'h0807_0605);

    // Same-edge consume and complete with distinct data, then drain.
    cyc(1'b1, 1'b1, 1'b1, 8'hC1, 1'b1);
    chk("sim_drained", {31'd0, valid_o}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 8'hC2, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 8'hC3, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 8'hC4, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'hD1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'hD2, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'hD3, 1'b0);
    chk("sim_hold", data_o, 32'hC4C3_C2C1);
    cyc(1'b1, 1'b1, 1'b0, 8'hD4, 1'b1);
    chk("sim_valid", {31'd0, valid_o}, 32'd1);
    chk("sim_data", data_o, 32'hD4D3_D2D1);

    // Enable low stalls the counter at S2.
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 8'h01, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 8'h02, 1'b1);
    enable_i = 1'b0; valid_i = 1'b1; sync_i = 1'b1; data_i = 8'h55; ready_i = 1'b1;
    #1;
    chk("en_ready_low", {31'd0, ready_o}, 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 8'h55, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 8'h66, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 8'h03, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 8'h04, 1'b1);
    chk("en_data", data_o, 32'h0403_0201);
    chk("en_err", {31'd0, err_o}, 32'd0);

    // Reset mid-group at S2: outputs clear, partial samples are gone.
    cyc(1'b1, 1'b1, 1'b1, 8'h01, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 8'h02, 1'b1);
    do_reset();
    chk("rst_no_err", {31'd0, err_o}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 8'h01, 1'b1);
    chk("rst_first_err", {31'd0, err_o}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 8'h02, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 8'h03, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 8'h04, 1'b1);
    chk("rst_group_valid", {31'd0, valid_o}, 32'd1);
    chk("rst_group_data", data_o, 32'h0403_0201);

    // Randomised traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 2) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cf_fft_1024_8_32_dmx4.md
CF_FFT_1024_8_32_DMX4 -- requirements
Module: cf_fft_1024_8_32_dmx4

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the width of one sample lane in bits.
REQ-002 SHALL have parameter LANES, fixed at 4, meaning the number of output lanes per group.
REQ-003 SHALL have port clock_c, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port enable_i, input, 1 bit: when low, no new sample is accepted.
REQ-006 SHALL have port valid_i, input, 1 bit: upstream sample is valid.
REQ-007 SHALL have port sync_i, input, 1 bit: marks the current sample as the first of a group (lane 0).
REQ-008 SHALL have port data_i, input, DATA_W bits: the serial sample.
REQ-009 SHALL have port ready_o, output, 1 bit: the block can accept a sample this cycle.
REQ-010 SHALL have port valid_o, output, 1 bit: data_o holds a complete 4-lane group.
REQ-011 SHALL have port ready_i, input, 1 bit: the downstream stage consumes data_o this cycle.
REQ-012 SHALL have port data_o, output, 4*DATA_W bits, laid out as {lane3, lane2, lane1, lane0}, with lane0 in the LSBs.
REQ-013 SHALL have port err_o, output, 1 bit: a one-cycle pulse indicating a partial group was discarded.

Function
REQ-014 SHALL accept a sample when enable_i && valid_i && ready_o are all high; this event is called "accept".
REQ-015 SHALL track the fill position with a 2-bit counter cnt taking states S0..S3; cnt is the lane the next accepted sample is written to.
REQ-016 SHALL, on an accept with sync_i=0, write data_i into fill lane cnt and advance cnt by 1, wrapping from S3 to S0.
REQ-017 SHALL, on an accept with sync_i=1, write data_i into fill lane 0 and set cnt to S1, regardless of the prior value of cnt.
REQ-018 SHALL, on an accept with sync_i=1 while cnt != S0, discard the partial group and pulse err_o high for exactly the next cycle.
REQ-019 SHALL, on an accept at S3 (sync_i=0), transfer fill lanes 0..2 plus data_i into the output register; valid_o rises on the following cycle, giving a latency of 1 clock from the 4th accept.
REQ-020 SHALL hold data_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-021 SHALL clear valid_o on the cycle after valid_o && ready_i, unless a new group completes in that same cycle, in which case valid_o stays 1 and data_o updates to the new group (no bubble).
REQ-022 SHALL drive ready_o = enable_i && ((cnt != S3) || !valid_o || ready_i); lanes 0..2 are buffered while the output register is full.
REQ-023 SHALL leave the output drain (valid_o/ready_i) independent of enable_i.
REQ-024 SHALL ignore sync_i and data_i when no accept occurs.
REQ-025 SHALL make data_o a registered output with no combinational path from data_i to data_o.

Reset
REQ-026 SHALL, while reset_n_i=0, asynchronously force cnt=S0, valid_o=0, err_o=0, data_o=0, and all fill lanes=0.
REQ-027 SHALL, on reset assertion mid-group, drop all partially collected samples, and SHALL NOT assert err_o as a result of the reset.
REQ-028 SHALL deassert reset in a way that is safe for synchronous release; the first accept is possible on the first rising edge after reset_n_i goes high.

Structure
REQ-029 SHALL take DATA_W and LANES and the cnt state encodings S0..S3 from the shared package cf_fft_pkg.
REQ-030 SHALL be a single flat module with no sub-module; the counter, fill registers, and output register are coded inline.
REQ-031 SHALL occupy 120-400 lines of RTL.

Verification
REQ-032 Bench SHALL cover the basic group: with ready_i=1, accept 0x11(sync), 0x22, 0x33, 0x44 on consecutive cycles -> one cycle after the 4th accept, valid_o=1 and data_o=0x44332211 for 1 cycle.
REQ-033 Bench SHALL cover backpressure: with ready_i=0, stream 8 samples 0x01..0x08 -> data_o=0x04030201 is held; ready_o=0 once cnt=S3 with 0x05..0x07 buffered; ready_i=1 for 1 cycle -> the next cycle shows data_o=0x08070605.
REQ-034 Bench SHALL cover a resync: accept 0xA1(sync), 0xA2, then 0xB1(sync), 0xB2, 0xB3, 0xB4 -> err_o pulses once after 0xB1; the output is 0xB4B3B2B1 only, with no 0xA* data.
REQ-035 Bench SHALL cover simultaneous events: the 4th accept of group N+1 on the same edge as ready_i consuming group N -> valid_o stays 1 and data_o switches directly to group N+1.
REQ-036 Bench SHALL cover enable and reset: enable_i=0 with valid_i=1 -> ready_o=0 and cnt unchanged; reset_n_i pulsed low at cnt=S2 -> immediately valid_o=0, data_o=0, err_o=0, and the next group 0x01..0x04 yields 0x04030201.
